regfile_write_port: RTL and testbench
=====================================

Name: regfile_write_port

Overview:
- Write-side companion to the 32-to-1 read multiplexer. It accepts register-write requests over a valid/ready handshake and buffers them in a small FIFO.
- It drains at most one request per clock into a 32 x 32-bit register bank, using a 5-to-32 one-hot decoder.
- The bank is exported as a flattened bus that feeds the I0..I31 inputs of the read multiplexer.

Parameters:
- DEPTH, 2: write-buffer entries; legal values 1..8.
- ZERO_R0, 0: when 1, writes to address 0 are consumed but discarded, so R0 reads 0 permanently.

Ports:
- Clk  input  1  rising-edge clock
- Clr_n  input  1  asynchronous active-low reset
- W_valid  input  1  write request present
- W_ready  output  1  buffer can accept a request this cycle
- W_addr  input  5  destination register index
- W_data  input  32  data to write
- Hold  input  1  stalls draining; requests are still accepted while space remains
- WE  output  32  one-hot write enable for the drain occurring this cycle; all 0 if no drain
- Count  output  4  number of buffered entries, 0..DEPTH
- Pending  output  1  Count != 0
- Q  output  1024  register bank; register k = Q[32k+31:32k]

Behaviour:
- Reset (Clr_n low, asynchronous; takes effect immediately and holds while low):
  - All 32 registers = 0; FIFO pointers and Count = 0.
  - Pending = 0, WE = 0, W_ready = 1.
  - Any in-flight or buffered writes are discarded, including mid-burst.
- Accept: a push happens at a rising edge when W_valid && W_ready. {W_addr, W_data} are stored at the tail.
- W_ready = (Count != DEPTH). It depends only on registered state, with no combinational path from W_valid. A drain in the same cycle does not open a slot early.
- Drain: when Count != 0 && !Hold, the head entry is popped at the rising edge and reg[head.addr] <= head.data.
- WE[head.addr] = 1 during that cycle. It is combinational from the head entry, Count and Hold.
- If ZERO_R0 = 1 and head.addr = 0, the pop still occurs, WE = 0 and the register is unchanged.
- Latency:
  - A request accepted at edge N into an empty buffer with Hold = 0 is visible on Q after edge N+1.
  - Each older buffered entry adds one cycle.
- Ordering: strict FIFO. Two writes to the same address resolve to the later one.
- Simultaneous push and pop in one cycle: Count unchanged. Both take effect; the pushed entry is never the one popped that cycle.
- Count arithmetic: Count_next = Count + push - pop. It never exceeds DEPTH and never goes below 0.
- Pointers are log2(DEPTH)-wide, wrapping modulo DEPTH. DEPTH non-power-of-2 must wrap explicitly at DEPTH-1.
- Hold = 1: no pops and WE = 0. Pushes continue until full, then W_ready = 0 until Hold drops.
- W_valid while W_ready = 0: ignored; the requester must hold the request stable (standard valid/ready).
- Registers not addressed by WE retain their value indefinitely.
- Q is purely registered; there is no bypass from W_data to Q.

Test Plan:
- Reset, then push addr=5 data=0x0000_0005 with Hold=0. WE=0x0000_0020 in the cycle after acceptance; Q[191:160]=0x5 after the next edge; Count returns to 0.
- Hold=1, push addr=1 data=0xAAAA_AAAA and addr=2 data=0xBBBB_BBBB. Count=2 and W_ready=0; a third request is stalled. Release Hold: R1 then R2 update on consecutive edges and W_ready returns to 1.
- Stream 32 writes k->data=k, back-to-back, with Hold=0. Sustained 1 write/cycle with Count toggling 1 to 0 or staying at 1. Afterwards, each register k reads k through the 32-to-1 mux for S=0..31.
- Same-address ordering: push addr=7 0x1111_1111 then addr=7 0x2222_2222. Final R7=0x2222_2222.
- ZERO_R0=1: push addr=0 data=0xDEAD_BEEF. The entry is consumed, WE=0 and R0 stays 0.
- Assert Clr_n low with 2 buffered entries and R3=0x33. Immediately Q=0, Count=0, Pending=0. After release, no stale write appears.

Source files
------------

// File: rtl/regfile_write_port.sv
// regfile_write_port: write side of the 32 x 32-bit register file.
// Write requests arrive over a valid/ready handshake and are buffered in a
// small FIFO (DEPTH entries, 1..8). At most one entry drains per clock into
// the register bank through a 5-to-32 one-hot decoder. The bank is exported
// flat on Q (register k = Q[32k+31:32k]) to feed the read multiplexer.
//
// Handshake (W_valid / W_ready):
//   - A push happens at a rising edge when W_valid && W_ready.
//   - W_ready = (Count != DEPTH). It is a function of registered state only.
//     There is no path from W_valid, and a drain in the same cycle does not
//     open a slot early.
//   - A requester that sees W_ready = 0 must hold W_valid, W_addr and W_data
//     stable until the push edge. A request while W_ready = 0 is ignored.
module regfile_write_port #(
  parameter int DEPTH   = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic          W_valid,
  output logic          W_ready,
  input  logic [4:0]    W_addr,
  input  logic [31:0]   W_data,
  input  logic          Hold,
  output logic [31:0]   WE,
  output logic [3:0]    Count,
  output logic          Pending,
  output logic [1023:0] Q
);

  // A single-entry buffer still needs a 1-bit pointer to keep types legal;
  // it simply never leaves zero.
  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       DEPTH_CNT = 4'(DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t           buf_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count_q;
  logic [31:0]      bank [32];

  entry_t           head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop_write;
  logic [31:0]      dec;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths are correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Buffer status and handshake decisions.
  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == 4'd0);
  assign W_ready = !full;
  assign push    = W_valid && W_ready;
  assign pop     = !empty && !Hold;
  assign head    = buf_mem[rd_ptr];

  // A write to R0 in zero-register mode is popped but never reaches the bank.
  assign drop_write = ZERO_R0 && (head.addr == 5'd0);

  // 5-to-32 one-hot decode of the head entry's destination register.
  always_comb begin
    dec = '0;
    for (int i = 0; i < 32; i++) begin
      dec[i] = (head.addr == 5'(i));
    end
  end

  // The drain enable is live in the cycle the pop happens, all zero otherwise.
  assign WE = (pop && !drop_write) ? dec : 32'h0;

  assign Count   = count_q;
  assign Pending = !empty;

  // Pointer and occupancy bookkeeping; push and pop in one cycle cancel out.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= 4'd0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage. A push never lands on the slot being popped: a push needs
  // a free slot and a pop needs an occupied one.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (push) begin
      buf_mem[wr_ptr] <= '{addr: W_addr, data: W_data};
    end
  end

  // Register bank: only the register selected by WE takes the head data.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      for (int i = 0; i < 32; i++) begin
        bank[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (WE[i]) begin
          bank[i] <= head.data;
        end
      end
    end
  end

  // Flatten the bank onto Q; purely registered, no bypass from W_data.
  for (genvar k = 0; k < 32; k++) begin : g_flat
    assign Q[32*k +: 32] = bank[k];
  end

  // Occupancy never exceeds the buffer size.
  a_count_bound : assert property (@(posedge Clk) disable iff (!Clr_n)
    count_q <= DEPTH_CNT);

  // At most one register is written per cycle.
  a_we_onehot : assert property (@(posedge Clk) disable iff (!Clr_n)
    $onehot0(WE));

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port. Instance A (DEPTH=2, ZERO_R0=0) is followed
// cycle by cycle by a queue-based reference model. Instance B (DEPTH=3,
// ZERO_R0=1) covers zero-register mode and non-power-of-2 wrap.
module tb_regfile_write_port;

  localparam int DEPTH_A = 2;
  localparam int DEPTH_B = 3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Clr_n;
  always #5 Clk = ~Clk;

  // ---------------- instance A signals ----------------
  logic          a_valid, a_ready, a_hold, a_pending;
  logic [4:0]    a_addr;
  logic [31:0]   a_data, a_we;
  logic [3:0]    a_count;
  logic [1023:0] a_q;

  // ---------------- instance B signals ----------------
  logic          b_valid, b_ready, b_hold, b_pending;
  logic [4:0]    b_addr;
  logic [31:0]   b_data, b_we;
  logic [3:0]    b_count;
  logic [1023:0] b_q;

  int checks   = 0;
  int failures = 0;

  regfile_write_port #(.DEPTH(DEPTH_A), .ZERO_R0(1'b0)) dut_a (
    .Clk(Clk), .Clr_n(Clr_n), .W_valid(a_valid), .W_ready(a_ready),
    .W_addr(a_addr), .W_data(a_data), .Hold(a_hold), .WE(a_we),
    .Count(a_count), .Pending(a_pending), .Q(a_q)
  );

  regfile_write_port #(.DEPTH(DEPTH_B), .ZERO_R0(1'b1)) dut_b (
    .Clk(Clk), .Clr_n(Clr_n), .W_valid(b_valid), .W_ready(b_ready),
    .W_addr(b_addr), .W_data(b_data), .Hold(b_hold), .WE(b_we),
    .Count(b_count), .Pending(b_pending), .Q(b_q)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Bench-side 32-to-1 read mux over the flattened bank.
  function automatic logic [31:0] rd(input logic [1023:0] q, input int s);
    return q[32*s +: 32];
  endfunction

  // Drivers: called 1 time unit after a rising edge; return 1 time unit after
  // the edge that accepted the request, with W_valid still high.
  task automatic send_a(input logic [4:0] a, input logic [31:0] d);
    int waited = 0;
    a_valid = 1'b1; a_addr = a; a_data = d;
    @(negedge Clk);
    while (!a_ready && waited < 40) begin
      waited++;
      @(negedge Clk);
    end
    if (!a_ready) begin
      checks++; failures++;
      $display("FAIL send_a_timeout: W_ready=0 for addr %0d, required 1", a);
    end
    @(posedge Clk); #1;
  endtask

  task automatic send_b(input logic [4:0] a, input logic [31:0] d);
    int waited = 0;
    b_valid = 1'b1; b_addr = a; b_data = d;
    @(negedge Clk);
    while (!b_ready && waited < 40) begin
      waited++;
      @(negedge Clk);
    end
    if (!b_ready) begin
      checks++; failures++;
      $display("FAIL send_b_timeout: W_ready=0 for addr %0d, required 1", a);
    end
    @(posedge Clk); #1;
  endtask

  task automatic drain_a();
    int n = 0;
    @(negedge Clk);
    while (a_count != 4'd0 && n < 40) begin
      n++;
      @(negedge Clk);
    end
    if (a_count != 4'd0) begin
      checks++; failures++;
      $display("FAIL drain_a_timeout: Count=%0d, required 0", a_count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic drain_b();
    int n = 0;
    @(negedge Clk);
    while (b_count != 4'd0 && n < 40) begin
      n++;
      @(negedge Clk);
    end
    if (b_count != 4'd0) begin
      checks++; failures++;
      $display("FAIL drain_b_timeout: Count=%0d, required 0", b_count);
    end
    @(posedge Clk); #1;
  endtask

  // ---------------- scoreboard for instance A ----------------
  // exp_q holds {addr, data} of accepted but not yet drained requests.
  logic [36:0] exp_q[$];
  logic [31:0] m_regs [32];
  int          m_count;

  initial begin
    logic [36:0]   e;
    logic [31:0]   exp_we;
    logic          do_pop;
    logic          do_push;
    logic [1023:0] m_flat;
    int            bad;
    m_count = 0;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
    forever begin
      @(negedge Clk);
      if (!Clr_n) begin
        exp_q.delete();
        m_count = 0;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      end else begin
        for (int k = 0; k < 32; k++) m_flat[32*k +: 32] = m_regs[k];
        checks++;
        if (a_q !== m_flat) begin
          failures++;
          bad = 0;
          for (int k = 31; k >= 0; k--) if (a_q[32*k +: 32] !== m_regs[k]) bad = k;
          $display("FAIL mon_q: R%0d got %h required %h", bad, a_q[32*bad +: 32], m_regs[bad]);
        end
        check("mon_count", a_count, m_count);
        check("mon_pending", a_pending, m_count != 0);
        check("mon_ready", a_ready, m_count != DEPTH_A);
        exp_we = 32'h0;
        do_pop = (m_count != 0) && !a_hold && (exp_q.size() > 0);
        if (do_pop) begin
          e = exp_q.pop_front();
          exp_we[e[36:32]] = 1'b1;
        end
        check("mon_we", a_we, exp_we);
        if (do_pop) m_regs[e[36:32]] = e[31:0];
        do_push = a_valid && (m_count != DEPTH_A);
        if (do_push) exp_q.push_back({a_addr, a_data});
        m_count = m_count + int'(do_push) - int'(do_pop);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_we;
  } vec_t;

  vec_t vecs [6];

  // ---------------- main stimulus ----------------
  initial begin
    int t0;
    Clr_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0; a_hold = 1'b0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_hold = 1'b0;

    vecs[0] = '{addr: 5'd5,  data: 32'h0000_0005, exp_we: 32'h0000_0020};
    vecs[1] = '{addr: 5'd0,  data: 32'h1234_5678, exp_we: 32'h0000_0001};
    vecs[2] = '{addr: 5'd31, data: 32'hFFFF_FFFF, exp_we: 32'h8000_0000};
    vecs[3] = '{addr: 5'd16, data: 32'hA5A5_5A5A, exp_we: 32'h0001_0000};
    vecs[4] = '{addr: 5'd10, data: 32'h0BAD_F00D, exp_we: 32'h0000_0400};
    vecs[5] = '{addr: 5'd3,  data: 32'h0000_0033, exp_we: 32'h0000_0008};

    // Reset state.
    #1;
    checks++;
    if (a_q !== 1024'h0) begin failures++; $display("FAIL reset_q: got nonzero bank, required 0"); end
    check("reset_count", a_count, 4'd0);
    check("reset_pending", a_pending, 1'b0);
    check("reset_we", a_we, 32'h0);
    check("reset_ready", a_ready, 1'b1);
    repeat (2) @(posedge Clk);
    #1 Clr_n = 1'b1;

    // Table: single write into an empty buffer; WE one cycle after accept,
    // data on Q after the following edge.
    for (int i = 0; i < 6; i++) begin
      send_a(vecs[i].addr, vecs[i].data);
      a_valid = 1'b0;
      @(negedge Clk);
      check($sformatf("vec%0d_we", i), a_we, vecs[i].exp_we);
      check($sformatf("vec%0d_count1", i), a_count, 4'd1);
      @(negedge Clk);
      check($sformatf("vec%0d_q", i), rd(a_q, int'(vecs[i].addr)), vecs[i].data);
      check($sformatf("vec%0d_count0", i), a_count, 4'd0);
      @(posedge Clk); #1;
    end

    // Hold: fill the buffer, stall a third request, then release.
    a_hold = 1'b1;
    send_a(5'd1, 32'hAAAA_AAAA);
    send_a(5'd2, 32'hBBBB_BBBB);
    a_addr = 5'd3; a_data = 32'hCCCC_CCCC;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("hold_count", a_count, 4'd2);
      check("hold_ready", a_ready, 1'b0);
      check("hold_we", a_we, 32'h0);
    end
    @(posedge Clk); #1;
    a_hold = 1'b0;
    @(negedge Clk);
    check("rel_we_r1", a_we, 32'h0000_0002);
    check("rel_r1_old", rd(a_q, 1), 32'h0);
    @(negedge Clk);
    check("rel_r1", rd(a_q, 1), 32'hAAAA_AAAA);
    check("rel_we_r2", a_we, 32'h0000_0004);
    check("rel_ready", a_ready, 1'b1);
    @(posedge Clk); #1;
    a_valid = 1'b0;
    @(negedge Clk);
    check("rel_r2", rd(a_q, 2), 32'hBBBB_BBBB);
    check("rel_count", a_count, 4'd1);
    @(posedge Clk); #1;
    drain_a();
    check("rel_r3", rd(a_q, 3), 32'hCCCC_CCCC);

    // Same-address ordering.
    send_a(5'd7, 32'h1111_1111);
    send_a(5'd7, 32'h2222_2222);
    a_valid = 1'b0;
    drain_a();
    check("same_addr_r7", rd(a_q, 7), 32'h2222_2222);

    // Back-to-back stream of 32 writes at one per cycle.
    t0 = int'($time);
    for (int k = 0; k < 32; k++) begin
      send_a(5'(k), 32'(k));
      check($sformatf("stream_count%0d", k), a_count, 4'd1);
    end
    a_valid = 1'b0;
    check("stream_cycles", 32'((int'($time) - t0) / 10), 32'd32);
    drain_a();
    for (int s = 0; s < 32; s++) begin
      check($sformatf("mux_s%0d", s), rd(a_q, s), 32'(s));
    end

    // Instance B: zero-register mode.
    send_b(5'd0, 32'hDEAD_BEEF);
    b_valid = 1'b0;
    @(negedge Clk);
    check("zr0_count1", b_count, 4'd1);
    check("zr0_we", b_we, 32'h0);
    @(negedge Clk);
    check("zr0_count0", b_count, 4'd0);
    check("zr0_r0", rd(b_q, 0), 32'h0);
    check("zr0_pending", b_pending, 1'b0);
    @(posedge Clk); #1;
    send_b(5'd4, 32'h4444_4444);
    b_valid = 1'b0;
    @(negedge Clk);
    check("zr0_we_r4", b_we, 32'h0000_0010);
    @(negedge Clk);
    check("zr0_r4", rd(b_q, 4), 32'h4444_4444);
    @(posedge Clk); #1;

    // Instance B: fill three entries, then stream so pointers wrap at 2.
    b_hold = 1'b1;
    for (int k = 10; k < 13; k++) send_b(5'(k), 32'h100 + 32'(k));
    b_valid = 1'b0;
    @(negedge Clk);
    check("b_full_count", b_count, 4'd3);
    check("b_full_ready", b_ready, 1'b0);
    @(posedge Clk); #1;
    b_hold = 1'b0;
    for (int k = 13; k < 21; k++) send_b(5'(k), 32'h100 + 32'(k));
    b_valid = 1'b0;
    drain_b();
    for (int k = 10; k < 21; k++) begin
      check($sformatf("b_wrap_r%0d", k), rd(b_q, k), 32'h100 + 32'(k));
    end

    // Asynchronous reset with two buffered entries and R3 = 0x33.
    send_a(5'd3, 32'h0000_0033);
    a_valid = 1'b0;
    drain_a();
    check("pre_rst_r3", rd(a_q, 3), 32'h0000_0033);
    a_hold = 1'b1;
    send_a(5'd8, 32'h8888_8888);
    send_a(5'd9, 32'h9999_9999);
    a_valid = 1'b0;
    #2 Clr_n = 1'b0;
    #1;
    checks++;
    if (a_q !== 1024'h0) begin failures++; $display("FAIL rst_q: bank not cleared immediately, required 0"); end
    check("rst_count", a_count, 4'd0);
    check("rst_pending", a_pending, 1'b0);
    check("rst_we", a_we, 32'h0);
    check("rst_ready", a_ready, 1'b1);
    repeat (2) @(posedge Clk);
    #1 Clr_n = 1'b1;
    a_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("post_rst_we", a_we, 32'h0);
      check("post_rst_count", a_count, 4'd0);
    end
    check("post_rst_r3", rd(a_q, 3), 32'h0);
    check("post_rst_r8", rd(a_q, 8), 32'h0);
    check("post_rst_r9", rd(a_q, 9), 32'h0);

    @(posedge Clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
